// File: rtl/spart_pkg.sv
// Shared constants, FSM state type and divisor helpers for the SPART echo driver.
package spart_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;
    localparam logic [1:0] ADDR_DB_LO  = 2'b10;
    localparam logic [1:0] ADDR_DB_HI  = 2'b11;

    localparam int unsigned BAUD_4800  = 4800;
    localparam int unsigned BAUD_9600  = 9600;
    localparam int unsigned BAUD_19200 = 19200;
    localparam int unsigned BAUD_38400 = 38400;

    typedef enum logic [2:0] {
        INIT_LO,
        INIT_HI,
        IDLE,
        RD,
        WR
    } state_e;

    // SPART samples at 16x the baud rate; the divisor counts down to zero, hence the -1.
    function automatic logic [15:0] baud_div(input int unsigned clk_hz, input int unsigned baud);
        return 16'((clk_hz / (16 * baud)) - 1);
    endfunction

    function automatic logic [7:0] case_flip(input logic [7:0] b);
        if ((b >= 8'h41 && b <= 8'h5A) || (b >= 8'h61 && b <= 8'h7A)) begin
            return b ^ 8'h20;
        end
        return b;
    endfunction

endpackage

// File: rtl/echo_fifo.sv
// Small synchronous FIFO buffering received bytes until the transmitter can take them.
module echo_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 8,
    localparam int unsigned AW = $clog2(Depth),
    localparam int unsigned CW = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] data_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    localparam logic [CW-1:0] DepthC = CW'(Depth);
    localparam logic [CW-1:0] One    = CW'(1);

    logic [Width-1:0] mem_q [Depth];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == DepthC);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Depth is a power of two, so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + One;
        end else if (do_pop && !do_push) begin
            count_d = count_q - One;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/spart_driver.sv
// Programs the SPART baud divisor from br_cfg, then echoes every received byte via a FIFO.
// Define CASE_FLIP_EN to swap the case of ASCII letters as they enter the FIFO.
module spart_driver
    import spart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 100000000,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  br_cfg,
    input  logic                        rda,
    input  logic                        tbr,
    output logic                        iocs,
    output logic                        iorw,
    output logic [1:0]                  ioaddr,
    inout  wire  [7:0]                  databus,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow
);

    localparam logic [15:0] Div4800  = baud_div(CLK_FREQ_HZ, BAUD_4800);
    localparam logic [15:0] Div9600  = baud_div(CLK_FREQ_HZ, BAUD_9600);
    localparam logic [15:0] Div19200 = baud_div(CLK_FREQ_HZ, BAUD_19200);
    localparam logic [15:0] Div38400 = baud_div(CLK_FREQ_HZ, BAUD_38400);

    function automatic logic [15:0] sel_div(input logic [1:0] sel);
        unique case (sel)
            2'b00:   return Div4800;
            2'b01:   return Div9600;
            2'b10:   return Div19200;
            default: return Div38400;
        endcase
    endfunction

    state_e     state_q, state_d;
    logic [1:0] br_s1_q, br_s2_q;
    logic [1:0] br_prog_q, br_prog_d;
    logic       overflow_q, overflow_d;
    logic       push, pop, full, empty;
    logic [7:0] head, rx_byte, bus_out;
    logic       bus_oe;
    logic [15:0] div_lo, div_hi;

    assign databus  = bus_oe ? bus_out : 8'hzz;
    assign overflow = overflow_q;

`ifdef CASE_FLIP_EN
    assign rx_byte = case_flip(databus);
`else
    assign rx_byte = databus;
`endif

    // Low byte uses the live synchronized setting and latches it, so the high byte always matches.
    assign div_lo = sel_div(br_s2_q);
    assign div_hi = sel_div(br_prog_q);

    always_comb begin
        state_d    = state_q;
        br_prog_d  = br_prog_q;
        overflow_d = overflow_q;
        push       = 1'b0;
        pop        = 1'b0;
        iocs       = 1'b0;
        iorw       = 1'b1;
        ioaddr     = ADDR_DATA;
        bus_oe     = 1'b0;
        bus_out    = 8'h00;
        unique case (state_q)
            INIT_LO: begin
                iocs      = 1'b1;
                iorw      = 1'b0;
                ioaddr    = ADDR_DB_LO;
                bus_oe    = 1'b1;
                bus_out   = div_lo[7:0];
                br_prog_d = br_s2_q;
                state_d   = INIT_HI;
            end
            INIT_HI: begin
                iocs    = 1'b1;
                iorw    = 1'b0;
                ioaddr  = ADDR_DB_HI;
                bus_oe  = 1'b1;
                bus_out = div_hi[15:8];
                state_d = IDLE;
            end
            IDLE: begin
                // A full FIFO with tbr set drains first so the incoming byte is not lost.
                if (br_s2_q != br_prog_q) begin
                    state_d = INIT_LO;
                end else if (rda && !(full && tbr)) begin
                    state_d = RD;
                end else if (tbr && !empty) begin
                    state_d = WR;
                end
            end
            RD: begin
                iocs = 1'b1;
                if (full) begin
                    overflow_d = 1'b1;
                end else begin
                    push = 1'b1;
                end
                state_d = IDLE;
            end
            WR: begin
                iocs    = 1'b1;
                iorw    = 1'b0;
                bus_oe  = 1'b1;
                bus_out = head;
                pop     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = INIT_LO;
        endcase
        if (rst) begin
            iocs   = 1'b0;
            iorw   = 1'b1;
            ioaddr = ADDR_DATA;
            bus_oe = 1'b0;
            push   = 1'b0;
            pop    = 1'b0;
        end
    end

    // Synchronizer keeps sampling through reset so the first divisor uses the real setting.
    always_ff @(posedge clk) begin
        br_s1_q <= br_cfg;
        br_s2_q <= br_s1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= INIT_LO;
            br_prog_q  <= 2'b00;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            br_prog_q  <= br_prog_d;
            overflow_q <= overflow_d;
        end
    end

    echo_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (8)
    ) u_echo_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (rx_byte),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (fifo_count)
    );

endmodule

// File: tb/tb_spart_driver.sv
// Directed bench for spart_driver: divisor programming, echo, overflow, arbitration, reset.
module tb_spart_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] br_cfg = 2'b01;
    logic       rda = 1'b0;
    logic       tbr = 1'b0;
    logic       iocs, iorw;
    logic [1:0] ioaddr;
    wire  [7:0] databus;
    logic [2:0] fifo_count;
    logic       overflow;
    logic [7:0] rx_data = 8'h00;

    int checks = 0;
    int failures = 0;

`ifdef CASE_FLIP_EN
    localparam logic [7:0] E41 = 8'h61;
    localparam logic [7:0] E55 = 8'h75;
`else
    localparam logic [7:0] E41 = 8'h41;
    localparam logic [7:0] E55 = 8'h55;
`endif

    always #5 clk = ~clk;

    // SPART model answers reads with rx_data.
    assign databus = (iocs && iorw) ? rx_data : 8'hzz;

    spart_driver #(
        .CLK_FREQ_HZ (100000000),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .br_cfg     (br_cfg),
        .rda        (rda),
        .tbr        (tbr),
        .iocs       (iocs),
        .iorw       (iorw),
        .ioaddr     (ioaddr),
        .databus    (databus),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Called at the negedge of an IDLE cycle; leaves at the negedge of the following IDLE cycle.
    task automatic read_byte(input logic [7:0] b);
        rx_data = b;
        rda = 1'b1;
        cyc();
        check("rd_access", {13'd0, iocs, iorw, ioaddr == 2'b00}, 16'h7);
        rda = 1'b0;
        cyc();
    endtask

    task automatic check_init(input string tag, input logic [7:0] lo, input logic [7:0] hi);
        check({tag, "_lo_ctl"}, {12'd0, iocs, iorw, ioaddr}, 16'hA);
        check({tag, "_lo_data"}, {8'd0, databus}, {8'd0, lo});
        cyc();
        check({tag, "_hi_ctl"}, {12'd0, iocs, iorw, ioaddr}, 16'hB);
        check({tag, "_hi_data"}, {8'd0, databus}, {8'd0, hi});
        cyc();
        check({tag, "_idle"}, {15'd0, iocs}, 16'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] exp4 [4];
        exp4[0] = 8'h21;
        exp4[1] = 8'h22;
        exp4[2] = 8'h23;
        exp4[3] = 8'h30;

        // Reset and divisor programming for 9600 baud (650 = 0x028A).
        repeat (4) cyc();
        check("rst_iocs", {15'd0, iocs}, 16'h0);
        check("rst_iorw", {15'd0, iorw}, 16'h1);
        check("rst_count", {13'd0, fifo_count}, 16'h0);
        check("rst_ovf", {15'd0, overflow}, 16'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        cyc();
        check_init("boot", 8'h8A, 8'h02);

        // Single echo: RD, IDLE, WR.
        rx_data = 8'h41;
        rda = 1'b1;
        tbr = 1'b1;
        cyc();
        check("echo_rd", {13'd0, iocs, iorw, ioaddr == 2'b00}, 16'h7);
        rda = 1'b0;
        cyc();
        check("echo_gap", {15'd0, iocs}, 16'h0);
        check("echo_cnt1", {13'd0, fifo_count}, 16'h1);
        cyc();
        check("echo_wr", {12'd0, iocs, iorw, ioaddr}, 16'h8);
        check("echo_data", {8'd0, databus}, {8'd0, E41});
        tbr = 1'b0;
        cyc();
        check("echo_cnt0", {13'd0, fifo_count}, 16'h0);

        // Overflow: five bytes into a four-entry FIFO.
        for (int i = 0; i < 5; i++) begin
            read_byte(8'h10 + 8'(i));
            if (i == 3) begin
                check("ovf_pre", {15'd0, overflow}, 16'h0);
            end
        end
        check("ovf_count", {13'd0, fifo_count}, 16'h4);
        check("ovf_flag", {15'd0, overflow}, 16'h1);
        tbr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("drain_wr", {13'd0, iocs, iorw, ioaddr == 2'b00}, 16'h5);
            check("drain_data", {8'd0, databus}, {8'd0, 8'h10 + 8'(i)});
            if (i == 3) tbr = 1'b0;
            cyc();
        end
        check("drain_cnt", {13'd0, fifo_count}, 16'h0);

        // Full FIFO with rda and tbr together: WR first, RD after an idle cycle.
        for (int i = 0; i < 4; i++) read_byte(8'h20 + 8'(i));
        check("full_cnt", {13'd0, fifo_count}, 16'h4);
        rx_data = 8'h30;
        rda = 1'b1;
        tbr = 1'b1;
        cyc();
        check("arb_wr", {14'd0, iocs, iorw}, 16'h2);
        check("arb_wr_data", {8'd0, databus}, 16'h20);
        cyc();
        check("arb_gap", {15'd0, iocs}, 16'h0);
        cyc();
        check("arb_rd", {14'd0, iocs, iorw}, 16'h3);
        rda = 1'b0;
        cyc();
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("arb_drain", {8'd0, databus}, {8'd0, exp4[i]});
            if (i == 3) tbr = 1'b0;
            cyc();
        end
        check("arb_cnt", {13'd0, fifo_count}, 16'h0);

        // Baud change to 38400 (161 = 0x00A1) with one byte held in the FIFO.
        read_byte(8'h55);
        br_cfg = 2'b11;
        cyc();
        check("sync1", {15'd0, iocs}, 16'h0);
        cyc();
        check("sync2", {15'd0, iocs}, 16'h0);
        cyc();
        check_init("rebaud", 8'hA1, 8'h00);
        check("rebaud_cnt", {13'd0, fifo_count}, 16'h1);
        tbr = 1'b1;
        cyc();
        check("rebaud_wr", {8'd0, databus}, {8'd0, E55});
        tbr = 1'b0;
        cyc();

        // Reset asserted during a WR cycle.
        read_byte(8'h66);
        tbr = 1'b1;
        cyc();
        check("pre_rst_wr", {14'd0, iocs, iorw}, 16'h2);
        rst = 1'b1;
        cyc();
        check("mid_rst", {13'd0, iocs, iorw, overflow}, 16'h2);
        check("mid_rst_cnt", {13'd0, fifo_count}, 16'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        tbr = 1'b0;
        cyc();
        check_init("reboot", 8'hA1, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
